i2s_sample_sequencer: RTL and testbench

Sample-level scheduler between the I2S2 controller and the shared audio processing datapath. It captures each ADC sample, issues it to the processing unit over a valid/ready handshake, collects the result, and presents it as the next DAC sample. It also owns the I2S runtime configuration (clock divider, ADC/DAC scale, mode) and applies changes only on sample boundaries. It reports overruns and processing timeouts.

---
 rtl/i2s_sample_sequencer_if.sv | 30 +++
 rtl/i2s_sample_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_i2s_sample_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_sample_sequencer_if.sv
// -----------------------------------------------------------------------------
// i2s_sample_sequencer_if
// Valid/ready link between the sample sequencer and the shared audio
// processing unit.
//   procData        sample issued to the processing unit
//   procValid       issue request, held until accepted or abandoned
//   procReady       processing unit accepts the request
//   procResult      processed sample
//   procResultValid one-cycle result strobe
// master: sequencer side, slave: processing unit side.
// -----------------------------------------------------------------------------
interface i2s_sample_sequencer_if #(
    parameter int DataWidth = 12
);
    logic [DataWidth-1:0] procData;
    logic                 procValid;
    logic                 procReady;
    logic [DataWidth-1:0] procResult;
    logic                 procResultValid;

    modport master (
        output procData, procValid,
        input  procReady, procResult, procResultValid
    );

    modport slave (
        input  procData, procValid,
        output procReady, procResult, procResultValid
    );
endinterface

// File: rtl/i2s_sample_sequencer.sv
// -----------------------------------------------------------------------------
// i2s_sample_sequencer
// Schedules one audio sample at a time between the I2S controller and the
// shared processing unit: captures an ADC sample on the rising edge of
// adcDataValid, optionally sends it through the processing unit, and presents
// the outcome as the next DAC sample. Owns the I2S runtime configuration and
// only changes it on accepted samples. Counts dropped samples and flags
// processing timeouts.
//   clk, reset          clock, synchronous active-high reset
//   cfgWrite/Addr/Data  shadow config write (0 clk div, 1 adc scale,
//                       2 dac scale, 3 mode: 0 bypass, 1 process, 2/3 mute)
//   clockConfig/adcScale/dacScale  active config to the I2S controller
//   adcData/adcDataValid           sample from the I2S controller
//   dacData/dacDataValid           sample to the I2S controller
//   proc                processing unit link (master side)
//   clearStatus         clears overrunCount and timeoutFlag
//   overrunCount        saturating dropped-sample count
//   timeoutFlag         sticky processing timeout
//   busy                a sample is in flight
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module i2s_sample_sequencer #(
    parameter int DataWidth        = 12,
    parameter int ClockConfigWidth = 4,
    parameter int ScaleWidth       = 6,
    parameter int TimeoutCycles    = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfgWrite_i,
    input  logic [1:0]                  cfgAddr_i,
    input  logic [7:0]                  cfgData_i,
    output logic [ClockConfigWidth-1:0] clockConfig_o,
    output logic [ScaleWidth-1:0]       adcScale_o,
    output logic [ScaleWidth-1:0]       dacScale_o,
    input  logic [DataWidth-1:0]        adcData_i,
    input  logic                        adcDataValid_i,
    output logic [DataWidth-1:0]        dacData_o,
    output logic                        dacDataValid_o,
    i2s_sample_sequencer_if.master      proc,
    input  logic                        clearStatus_i,
    output logic [7:0]                  overrunCount_o,
    output logic                        timeoutFlag_o,
    output logic                        busy_o
);
    localparam int                   CntWidth   = $clog2(TimeoutCycles);
    localparam logic [CntWidth-1:0]  CntLast    = CntWidth'(TimeoutCycles - 1);
    localparam logic [ScaleWidth-1:0] ScaleReset = ScaleWidth'(12);
    localparam logic [1:0]           ModeBypass  = 2'd0;
    localparam logic [1:0]           ModeProcess = 2'd1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_e;

    state_e                      state_q, state_d;
    logic                        adcValidPrev_q;
    logic [DataWidth-1:0]        sample_q, sample_d;
    logic [DataWidth-1:0]        result_q, result_d;
    logic                        procValid_q, procValid_d;
    logic [CntWidth-1:0]         cnt_q, cnt_d;
    logic [DataWidth-1:0]        dacData_q, dacData_d;
    logic                        dacValid_q, dacValid_d;
    logic [7:0]                  ovr_q, ovr_d;
    logic                        tmo_q, tmo_d;
    logic [ClockConfigWidth-1:0] shClk_q, shClk_d, actClk_q, actClk_d;
    logic [ScaleWidth-1:0]       shAdc_q, shAdc_d, actAdc_q, actAdc_d;
    logic [ScaleWidth-1:0]       shDac_q, shDac_d, actDac_q, actDac_d;
    logic [1:0]                  shMode_q, shMode_d;

    logic sampleEvent, commit, timeout, overrun;
    logic unused_cfg_bits;

    // Each field keeps only the low bits it needs.
    assign unused_cfg_bits = ^cfgData_i;

    assign sampleEvent = adcDataValid_i && !adcValidPrev_q;
    assign overrun     = sampleEvent && (state_q != IDLE);

    // Sequencer FSM
    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        result_d    = result_q;
        procValid_d = procValid_q;
        cnt_d       = cnt_q;
        dacData_d   = dacData_q;
        dacValid_d  = dacValid_q;
        commit      = 1'b0;
        timeout     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sampleEvent) begin
                    commit   = 1'b1;
                    sample_d = adcData_i;
                    // Route on the mode being committed now, not the old one.
                    if (shMode_q == ModeProcess) begin
                        state_d     = ISSUE;
                        procValid_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        state_d  = DELIVER;
                        result_d = (shMode_q == ModeBypass) ? adcData_i : '0;
                    end
                end
            end
            ISSUE: begin
                // Timeout wins over a handshake on the last allowed cycle.
                if (cnt_q == CntLast) begin
                    timeout     = 1'b1;
                    state_d     = IDLE;
                    procValid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (proc.procReady) begin
                        state_d     = WAIT;
                        procValid_d = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (proc.procResultValid) begin
                    result_d = proc.procResult;
                    state_d  = DELIVER;
                end else if (cnt_q == CntLast) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DELIVER: begin
                dacData_d  = result_q;
                dacValid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Config shadow/active and status
    always_comb begin
        shClk_d  = shClk_q;
        shAdc_d  = shAdc_q;
        shDac_d  = shDac_q;
        shMode_d = shMode_q;
        actClk_d = actClk_q;
        actAdc_d = actAdc_q;
        actDac_d = actDac_q;
        ovr_d    = ovr_q;
        tmo_d    = tmo_q;
        if (cfgWrite_i) begin
            unique case (cfgAddr_i)
                2'd0:    shClk_d  = cfgData_i[ClockConfigWidth-1:0];
                2'd1:    shAdc_d  = cfgData_i[ScaleWidth-1:0];
                2'd2:    shDac_d  = cfgData_i[ScaleWidth-1:0];
                default: shMode_d = cfgData_i[1:0];
            endcase
        end
        if (commit) begin
            actClk_d = shClk_q;
            actAdc_d = shAdc_q;
            actDac_d = shDac_q;
        end
        // A clear in the same cycle swallows any new overrun/timeout.
        if (clearStatus_i) begin
            ovr_d = '0;
            tmo_d = 1'b0;
        end else begin
            if (overrun && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
            if (timeout)                   tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            adcValidPrev_q <= 1'b0;
            sample_q       <= '0;
            result_q       <= '0;
            procValid_q    <= 1'b0;
            cnt_q          <= '0;
            dacData_q      <= '0;
            dacValid_q     <= 1'b0;
            ovr_q          <= '0;
            tmo_q          <= 1'b0;
            shClk_q        <= '0;
            shAdc_q        <= ScaleReset;
            shDac_q        <= ScaleReset;
            shMode_q       <= ModeBypass;
            actClk_q       <= '0;
            actAdc_q       <= ScaleReset;
            actDac_q       <= ScaleReset;
        end else begin
            state_q        <= state_d;
            adcValidPrev_q <= adcDataValid_i;
            sample_q       <= sample_d;
            result_q       <= result_d;
            procValid_q    <= procValid_d;
            cnt_q          <= cnt_d;
            dacData_q      <= dacData_d;
            dacValid_q     <= dacValid_d;
            ovr_q          <= ovr_d;
            tmo_q          <= tmo_d;
            shClk_q        <= shClk_d;
            shAdc_q        <= shAdc_d;
            shDac_q        <= shDac_d;
            shMode_q       <= shMode_d;
            actClk_q       <= actClk_d;
            actAdc_q       <= actAdc_d;
            actDac_q       <= actDac_d;
        end
    end

    assign proc.procValid = procValid_q;
    assign proc.procData  = sample_q;
    assign clockConfig_o  = actClk_q;
    assign adcScale_o     = actAdc_q;
    assign dacScale_o     = actDac_q;
    assign dacData_o      = dacData_q;
    assign dacDataValid_o = dacValid_q;
    assign overrunCount_o = ovr_q;
    assign timeoutFlag_o  = tmo_q;
    assign busy_o         = (state_q != IDLE);
endmodule

// File: tb/tb_i2s_sample_sequencer.sv
// -----------------------------------------------------------------------------
// tb_i2s_sample_sequencer
// Directed scenarios followed by randomized sample transactions. Expected
// values come from a transaction-level model: shadow/active config, last
// delivered DAC sample, dropped-sample count and timeout flag.
// -----------------------------------------------------------------------------
module tb_i2s_sample_sequencer;
    localparam int DW  = 12;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfgWrite = 1'b0;
    logic [1:0]    cfgAddr = '0;
    logic [7:0]    cfgData = '0;
    logic [3:0]    clockConfig;
    logic [5:0]    adcScale, dacScale;
    logic [DW-1:0] adcData = '0;
    logic          adcDataValid = 1'b0;
    logic [DW-1:0] dacData;
    logic          dacDataValid;
    logic          clearStatus = 1'b0;
    logic [7:0]    overrunCount;
    logic          timeoutFlag, busy;

    i2s_sample_sequencer_if #(.DataWidth(DW)) pif ();

    always #5 clk = ~clk;

    i2s_sample_sequencer #(
        .DataWidth(DW), .ClockConfigWidth(4), .ScaleWidth(6), .TimeoutCycles(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .cfgWrite_i(cfgWrite), .cfgAddr_i(cfgAddr), .cfgData_i(cfgData),
        .clockConfig_o(clockConfig), .adcScale_o(adcScale), .dacScale_o(dacScale),
        .adcData_i(adcData), .adcDataValid_i(adcDataValid),
        .dacData_o(dacData), .dacDataValid_o(dacDataValid),
        .proc(pif.master),
        .clearStatus_i(clearStatus), .overrunCount_o(overrunCount),
        .timeoutFlag_o(timeoutFlag), .busy_o(busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [3:0]    shClk, actClk;
    logic [5:0]    shAdc, actAdc, shDac, actDac;
    logic [1:0]    shMode;
    logic [DW-1:0] expDac;
    logic          expDacV, expTmo;
    int            expOvr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        shClk = 4'd0;  actClk = 4'd0;
        shAdc = 6'd12; actAdc = 6'd12;
        shDac = 6'd12; actDac = 6'd12;
        shMode = 2'd0;
        expDac = '0; expDacV = 1'b0; expOvr = 0; expTmo = 1'b0;
    endtask

    task automatic cfg_write(input int a, input logic [7:0] dat);
        cfgWrite = 1'b1; cfgAddr = 2'(a); cfgData = dat;
        step();
        cfgWrite = 1'b0;
        case (a)
            0:       shClk  = dat[3:0];
            1:       shAdc  = dat[5:0];
            2:       shDac  = dat[5:0];
            default: shMode = dat[1:0];
        endcase
    endtask

    // Present a sample and take the edge where the DUT accepts it.
    task automatic sample(input logic [DW-1:0] d);
        adcData = d; adcDataValid = 1'b1;
        step();
        adcDataValid = 1'b0;
        actClk = shClk; actAdc = shAdc; actDac = shDac;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_clk"},  clockConfig,  actClk);
        chk({tag, "_adcs"}, adcScale,     actAdc);
        chk({tag, "_dacs"}, dacScale,     actDac);
        chk({tag, "_dac"},  dacData,      expDac);
        chk({tag, "_dacv"}, dacDataValid, expDacV);
        chk({tag, "_ovr"},  overrunCount, expOvr);
        chk({tag, "_tmo"},  timeoutFlag,  expTmo);
        chk({tag, "_busy"}, busy,         1'b0);
        chk({tag, "_pv"},   pif.procValid, 1'b0);
    endtask

    task automatic rand_txn();
        logic [DW-1:0] d, res;
        int r, s, inj;
        logic v, pv;
        if ($urandom_range(0, 5) == 0) begin
            clearStatus = 1'b1; step(); clearStatus = 1'b0;
            expOvr = 0; expTmo = 1'b0;
        end
        repeat ($urandom_range(0, 2)) cfg_write($urandom_range(0, 3), 8'($urandom));
        d = DW'($urandom);
        sample(d);
        if (shMode == 2'd1) begin
            chk("rnd_pv", pif.procValid, 1'b1);
            chk("rnd_pd", pif.procData, d);
            r = $urandom_range(0, 6);
            s = $urandom_range(0, 12);
            res = DW'($urandom);
            // Cycles from issue count 0..TMO-1; ready after r stall cycles,
            // result s cycles into the wait.
            repeat (r) step();
            pif.procReady = 1'b1; step(); pif.procReady = 1'b0;
            pv = 1'b0; inj = 0;
            for (int j = 0; j < s && r + 1 + j <= TMO - 1; j++) begin
                v = 1'($urandom_range(0, 1));
                if (v && !pv) inj++;
                adcDataValid = v; pv = v;
                step();
            end
            adcDataValid = 1'b0;
            if (r + 1 + s <= TMO - 1) begin
                pif.procResult = res; pif.procResultValid = 1'b1;
                step();
                pif.procResultValid = 1'b0;
                step();
                expDac = res; expDacV = 1'b1;
            end else begin
                expTmo = 1'b1;
                step();
            end
            expOvr = (expOvr + inj > 255) ? 255 : expOvr + inj;
        end else begin
            step();
            expDac = (shMode == 2'd0) ? d : '0;
            expDacV = 1'b1;
        end
        chk_state("rnd");
    endtask

    initial begin
        pif.procReady = 1'b0; pif.procResult = '0; pif.procResultValid = 1'b0;
        model_reset();
        step(); step();
        reset = 1'b0;

        // Reset state
        chk("rst_pd", pif.procData, '0);
        chk_state("rst");

        // Bypass
        sample(12'h5A3);
        chk("byp_busy1", busy, 1'b1);
        chk("byp_dac_early", dacData, 12'h000);
        step();
        expDac = 12'h5A3; expDacV = 1'b1;
        chk_state("byp");

        // Process with stalled ready, mid-transaction adcScale write
        cfg_write(3, 8'd1);
        sample(12'h123);
        chk("proc_pv", pif.procValid, 1'b1);
        repeat (3) begin
            step();
            chk("proc_stall_pd", pif.procData, 12'h123);
            chk("proc_stall_pv", pif.procValid, 1'b1);
        end
        pif.procReady = 1'b1; step(); pif.procReady = 1'b0;
        chk("proc_pv_drop", pif.procValid, 1'b0);
        cfg_write(1, 8'd20);
        chk("cfg_adc_hold", adcScale, 6'd12);
        repeat (3) step();
        pif.procResult = 12'hEDC; pif.procResultValid = 1'b1;
        step();
        pif.procResultValid = 1'b0;
        chk("proc_dac_early", dacData, 12'h5A3);
        step();
        expDac = 12'hEDC;
        chk_state("proc");

        // Config commit on next sample, upper bits dropped
        cfg_write(0, 8'hFF);
        cfg_write(3, 8'd0);
        chk("cfg_adc_pre", adcScale, 6'd12);
        sample(12'h0AB);
        chk("cfg_adc_20", adcScale, 6'd20);
        chk("cfg_clk_f", clockConfig, 4'hF);
        step();
        expDac = 12'h0AB;
        chk_state("cfg");

        // Mute
        cfg_write(3, 8'd2);
        sample(12'h7FF);
        step();
        expDac = '0;
        chk_state("mute");

        // Timeout, then a late result in IDLE
        cfg_write(3, 8'd1);
        sample(12'h456);
        pif.procReady = 1'b1; step(); pif.procReady = 1'b0;
        repeat (TMO - 2) step();
        chk("tmo_busy_pre", busy, 1'b1);
        chk("tmo_flag_pre", timeoutFlag, 1'b0);
        step();
        expTmo = 1'b1;
        chk_state("tmo");
        pif.procResult = 12'h999; pif.procResultValid = 1'b1;
        step();
        pif.procResultValid = 1'b0;
        step();
        chk_state("tmo_late");

        // Overrun during WAIT
        sample(12'h111);
        pif.procReady = 1'b1; step(); pif.procReady = 1'b0;
        adcData = 12'h333; adcDataValid = 1'b1; step(); adcDataValid = 1'b0;
        chk("ovr_one", overrunCount, 8'd1);
        pif.procResult = 12'h222; pif.procResultValid = 1'b1;
        step();
        pif.procResultValid = 1'b0;
        chk("ovr_pd_kept", pif.procData, 12'h111);
        step();
        expDac = 12'h222; expOvr = 1;
        chk_state("ovr");

        // Overrun saturation: 8 dropped samples per timed-out issue
        for (int k = 0; k < 38; k++) begin
            sample(DW'(k));
            for (int c = 0; c < TMO; c++) begin
                adcDataValid = (c % 2 == 1);
                step();
            end
            adcDataValid = 1'b0;
            step();
        end
        expOvr = 255; expTmo = 1'b1;
        chk_state("sat");
        clearStatus = 1'b1; step(); clearStatus = 1'b0;
        expOvr = 0; expTmo = 1'b0;
        chk_state("clr");

        // Randomized transactions
        for (int n = 0; n < 60; n++) rand_txn();

        // Reset in WAIT restores outputs and config defaults
        cfg_write(0, 8'h07);
        cfg_write(3, 8'd1);
        sample(12'hABC);
        pif.procReady = 1'b1; step(); pif.procReady = 1'b0;
        chk("rst_wait_busy", busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        chk("rst2_pd", pif.procData, '0);
        chk_state("rst2");
        // Shadow mode is back to bypass
        sample(12'h3C5);
        step();
        expDac = 12'h3C5; expDacV = 1'b1;
        chk_state("rst2_byp");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
